// File: rtl/instr_fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue: FSM state,
// PC increment, and the {pc, data} queue entry layout.
package instr_fetch_queue_pkg;

  typedef enum logic {
    FETCH = 1'b0,
    FLUSH = 1'b1
  } fetch_state_e;

  localparam int unsigned PC_INCR   = 4;
  localparam int unsigned FQ_ADDR_W = 32;
  localparam int unsigned FQ_DATA_W = 32;

  typedef struct packed {
    logic [FQ_ADDR_W-1:0] pc;
    logic [FQ_DATA_W-1:0] data;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_queue_fifo.sv
// Synchronous FIFO for fetched words: registered output (no bypass), flush clears
// pointers, and a full FIFO accepts a push in the same cycle it is popped.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output logic [W-1:0]  rdata_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= wdata_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (do_pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch front-end: owns the PC, issues credit-limited in-order fetches, queues
// returned words with their PC, and handles redirect by flushing and dropping stale
// responses. Define FETCH_PERF_EN to add the stall_cycles starvation counter.
module instr_fetch_queue #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req_valid,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_rsp_valid,
  input  logic [DATA_W-1:0] imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       stall_cycles
`endif
);
  import instr_fetch_queue_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = ADDR_W + DATA_W;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]     out_q, out_d;
  logic [CW-1:0]     drop_q, drop_d;

  logic [CW-1:0]     fifo_cnt;
  logic              fifo_full, fifo_empty;
  logic [EW-1:0]     fifo_rdata;
  logic              fifo_push, fifo_pop;
  logic [CW:0]       credit;
  logic              fire, rsp_keep, rsp_drop;

  // Outstanding requests plus queued words never exceed DEPTH, so responses always fit.
  assign credit         = {1'b0, out_q} + {1'b0, fifo_cnt};
  assign imem_req_valid = ~reset & (state_q == FETCH) & (credit < (CW+1)'(DEPTH));
  assign imem_req_addr  = pc_q;
  assign fire           = imem_req_valid & imem_req_ready;

  assign rsp_drop = imem_rsp_valid & (drop_q != '0);
  assign rsp_keep = imem_rsp_valid & (drop_q == '0);
  assign out_d    = out_q + CW'(fire) - CW'(imem_rsp_valid);

  assign fifo_push = rsp_keep & ~redirect_valid;
  assign fifo_pop  = instr_valid & instr_ready & ~redirect_valid;

  always_comb begin
    state_d  = state_q;
    pc_d     = fire ? pc_q + ADDR_W'(PC_INCR) : pc_q;
    rsp_pc_d = rsp_keep ? rsp_pc_q + ADDR_W'(PC_INCR) : rsp_pc_q;
    drop_d   = drop_q - CW'(rsp_drop);
    if (redirect_valid) begin
      // Everything still in flight after this cycle is stale, including a same-cycle fire.
      pc_d     = redirect_pc;
      rsp_pc_d = redirect_pc;
      drop_d   = out_d;
      state_d  = (out_d != '0) ? FLUSH : FETCH;
    end else if (state_q == FLUSH && drop_d == '0) begin
      state_d = FETCH;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      out_q    <= '0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      out_q    <= out_d;
      drop_q   <= drop_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .push_i  (fifo_push),
    .wdata_i ({rsp_pc_q, imem_rsp_data}),
    .pop_i   (fifo_pop),
    .flush_i (redirect_valid),
    .rdata_o (fifo_rdata),
    .count_o (fifo_cnt),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign instr_valid = ~fifo_empty;
  assign instr_pc    = fifo_rdata[EW-1:DATA_W];
  assign instr_data  = fifo_rdata[DATA_W-1:0];

  rsp_overflow_a: assert property (@(posedge clk) disable iff (reset)
    !(fifo_push && fifo_full && !fifo_pop));

`ifdef FETCH_PERF_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_q <= '0;
    else if (instr_ready && !instr_valid && stall_q != '1) stall_q <= stall_q + 32'd1;
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue with a 1-cycle-latency memory model.
module tb_instr_fetch_queue;
  import instr_fetch_queue_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid, instr_ready;
  logic [31:0] instr_data, instr_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] stall_cycles;
`endif

  int checks = 0, errors = 0, cyc = 0, nvld = 0;
  bit rsp_en;
  logic [31:0]  memq[$];
  logic [31:0]  reqlog[$];
  fetch_entry_t dlog[$];
  int           dcyc[$];
  logic         lv_instr_valid, lv_req_valid;
  logic [31:0]  lv_req_addr;

  instr_fetch_queue dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready)
`ifdef FETCH_PERF_EN
    ,
    .stall_cycles   (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    if (a < 32'd16) return (a >> 2) + 32'd1;
    else if (a == 32'd16) return 32'hA;
    else return 32'hC000_0000 ^ a;
  endfunction

  task automatic mem_drive();
    if (!imem_rsp_valid && rsp_en && memq.size() > 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = word(memq.pop_front());
    end
  endtask

  task automatic tick();
    logic f;
    logic [31:0] fa;
    fetch_entry_t e;
    @(negedge clk);
    lv_instr_valid = instr_valid;
    lv_req_valid   = imem_req_valid;
    lv_req_addr    = imem_req_addr;
    f  = imem_req_valid && imem_req_ready;
    fa = imem_req_addr;
    if (!imem_req_valid) nvld++;
    if (f) reqlog.push_back(fa);
    if (instr_valid && instr_ready && !redirect_valid && !reset) begin
      e.pc = instr_pc;
      e.data = instr_data;
      dlog.push_back(e);
      dcyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (f) memq.push_back(fa);
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    mem_drive();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0;
    redirect_valid = 0; redirect_pc = 0; instr_ready = 0; rsp_en = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    memq.delete(); reqlog.delete(); dlog.delete(); dcyc.delete();
    nvld = 0;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_instr_valid: got %b expected 0", instr_valid); end
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b expected 0", imem_req_valid); end
    checks++; if (imem_req_addr !== 32'h0) begin errors++; $display("FAIL reset_req_addr: got %h expected 0", imem_req_addr); end
    checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL reset_instr_pc: got %h expected 0", instr_pc); end
    checks++; if (instr_data !== 32'h0) begin errors++; $display("FAIL reset_instr_data: got %h expected 0", instr_data); end
    do_reset();
    tick();
    checks++; if (lv_req_valid !== 1'b1) begin errors++; $display("FAIL post_reset_req_valid: got %b expected 1", lv_req_valid); end
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc [5];
    logic [31:0] exp_dat [5];
    exp_pc  = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
    exp_dat = '{32'h1, 32'h2, 32'h3, 32'h4, 32'hA};
    do_reset();
    imem_req_ready = 1; rsp_en = 1; instr_ready = 1;
    repeat (5) tick();
    imem_req_ready = 0;
    repeat (4) tick();
    checks++; if (reqlog.size() != 5) begin errors++; $display("FAIL stream_req_count: got %0d expected 5", reqlog.size()); end
    checks++; if (dlog.size() != 5) begin errors++; $display("FAIL stream_dlv_count: got %0d expected 5", dlog.size()); end
    for (int i = 0; i < 5 && i < reqlog.size(); i++) begin
      checks++; if (reqlog[i] !== exp_pc[i]) begin errors++; $display("FAIL stream_req_addr[%0d]: got %h expected %h", i, reqlog[i], exp_pc[i]); end
    end
    for (int i = 0; i < 5 && i < dlog.size(); i++) begin
      checks++; if (dlog[i].pc !== exp_pc[i]) begin errors++; $display("FAIL stream_pc[%0d]: got %h expected %h", i, dlog[i].pc, exp_pc[i]); end
      checks++; if (dlog[i].data !== exp_dat[i]) begin errors++; $display("FAIL stream_data[%0d]: got %h expected %h", i, dlog[i].data, exp_dat[i]); end
      checks++; if (dcyc[i] != dcyc[0] + i) begin errors++; $display("FAIL stream_rate[%0d]: got cycle %0d expected %0d", i, dcyc[i], dcyc[0] + i); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_pc [5];
    logic [31:0] exp_dat [5];
    exp_pc  = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
    exp_dat = '{32'h1, 32'h2, 32'h3, 32'h4, 32'hA};
    do_reset();
    imem_req_ready = 1; rsp_en = 1; instr_ready = 0;
    repeat (6) tick();
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_valid_full: got %b expected 0", imem_req_valid); end
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL bp_instr_valid: got %b expected 1", instr_valid); end
    checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL bp_head_pc: got %h expected 0", instr_pc); end
    checks++; if (reqlog.size() != 4) begin errors++; $display("FAIL bp_req_count: got %0d expected 4", reqlog.size()); end
    instr_ready = 1;
    repeat (6) tick();
    imem_req_ready = 0;
    repeat (4) tick();
    checks++; if (reqlog.size() < 5 || reqlog[4] !== 32'h10) begin errors++; $display("FAIL bp_resume_addr: got %h expected 10", reqlog.size() >= 5 ? reqlog[4] : 32'hX); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= dlog.size()) begin errors++; $display("FAIL bp_dlv[%0d]: got none expected pc %h", i, exp_pc[i]); end
      else if (dlog[i].pc !== exp_pc[i] || dlog[i].data !== exp_dat[i]) begin
        errors++; $display("FAIL bp_dlv[%0d]: got %h/%h expected %h/%h", i, dlog[i].pc, dlog[i].data, exp_pc[i], exp_dat[i]);
      end
    end
  endtask

  task automatic test_redirect_flush();
    do_reset();
    imem_req_ready = 1; rsp_en = 0; instr_ready = 1;
    repeat (3) tick();
    imem_req_ready = 0; redirect_valid = 1; redirect_pc = 32'h100;
    tick();
    redirect_valid = 0; imem_req_ready = 1; rsp_en = 1;
    mem_drive();
    nvld = 0;
    tick();
    checks++; if (lv_instr_valid !== 1'b0) begin errors++; $display("FAIL flush_instr_valid: got %b expected 0", lv_instr_valid); end
    checks++; if (lv_req_valid !== 1'b0) begin errors++; $display("FAIL flush_req_valid: got %b expected 0", lv_req_valid); end
    repeat (5) tick();
    checks++; if (nvld != 3) begin errors++; $display("FAIL flush_cycles: got %0d expected 3", nvld); end
    checks++; if (reqlog.size() < 4 || reqlog[3] !== 32'h100) begin errors++; $display("FAIL flush_next_addr: got %h expected 100", reqlog.size() >= 4 ? reqlog[3] : 32'hX); end
    checks++; if (dlog.size() < 1 || dlog[0].pc !== 32'h100 || dlog[0].data !== 32'hC000_0100) begin
      errors++; $display("FAIL flush_first_instr: got %h/%h expected 100/c0000100", dlog.size() ? dlog[0].pc : 32'hX, dlog.size() ? dlog[0].data : 32'hX);
    end
  endtask

  task automatic test_redirect_collide();
    int stale;
    do_reset();
    imem_req_ready = 1; rsp_en = 1; instr_ready = 0;
    repeat (2) tick();
    redirect_valid = 1; redirect_pc = 32'h200; instr_ready = 1;
    tick();
    checks++; if (lv_req_valid !== 1'b1 || lv_req_addr !== 32'h8) begin errors++; $display("FAIL coll_fire: got %b/%h expected 1/8", lv_req_valid, lv_req_addr); end
    checks++; if (lv_instr_valid !== 1'b1) begin errors++; $display("FAIL coll_head_shown: got %b expected 1", lv_instr_valid); end
    redirect_valid = 0;
    tick();
    checks++; if (lv_instr_valid !== 1'b0 || lv_req_valid !== 1'b0) begin errors++; $display("FAIL coll_flush: got valid %b req %b expected 0 0", lv_instr_valid, lv_req_valid); end
    repeat (5) tick();
    checks++; if (reqlog.size() < 4 || reqlog[3] !== 32'h200) begin errors++; $display("FAIL coll_next_addr: got %h expected 200", reqlog.size() >= 4 ? reqlog[3] : 32'hX); end
    checks++; if (dlog.size() < 1 || dlog[0].pc !== 32'h200 || dlog[0].data !== 32'hC000_0200) begin
      errors++; $display("FAIL coll_first_instr: got %h/%h expected 200/c0000200", dlog.size() ? dlog[0].pc : 32'hX, dlog.size() ? dlog[0].data : 32'hX);
    end
    stale = 0;
    foreach (dlog[i]) if (dlog[i].pc < 32'h200) stale++;
    checks++; if (stale != 0) begin errors++; $display("FAIL coll_stale: got %0d stale words expected 0", stale); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    imem_req_ready = 1; rsp_en = 1; instr_ready = 0;
    repeat (2) tick();
    rsp_en = 0;
    repeat (2) tick();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin errors++; $display("FAIL mid_queued: got %b/%h expected 1/0", instr_valid, instr_pc); end
    #2 reset = 1'b1;
    #1;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL mid_instr_valid: got %b expected 0", instr_valid); end
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL mid_req_valid: got %b expected 0", imem_req_valid); end
    checks++; if (imem_req_addr !== 32'h0) begin errors++; $display("FAIL mid_req_addr: got %h expected 0", imem_req_addr); end
    do_reset();
    imem_req_ready = 1; rsp_en = 1; instr_ready = 1;
    repeat (4) tick();
    checks++; if (reqlog.size() < 1 || reqlog[0] !== 32'h0) begin errors++; $display("FAIL mid_restart_addr: got %h expected 0", reqlog.size() ? reqlog[0] : 32'hX); end
    checks++; if (dlog.size() < 1 || dlog[0].pc !== 32'h0 || dlog[0].data !== 32'h1) begin
      errors++; $display("FAIL mid_restart_instr: got %h/%h expected 0/1", dlog.size() ? dlog[0].pc : 32'hX, dlog.size() ? dlog[0].data : 32'hX);
    end
  endtask

`ifdef FETCH_PERF_EN
  task automatic test_perf();
    do_reset();
    checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL perf_reset: got %0d expected 0", stall_cycles); end
    imem_req_ready = 0; instr_ready = 1;
    repeat (7) tick();
    checks++; if (stall_cycles !== 32'd7) begin errors++; $display("FAIL perf_count: got %0d expected 7", stall_cycles); end
    instr_ready = 0;
    repeat (2) tick();
    checks++; if (stall_cycles !== 32'd7) begin errors++; $display("FAIL perf_hold: got %0d expected 7", stall_cycles); end
  endtask
`endif

  initial begin
    reset = 1'b0;
    imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0;
    redirect_valid = 0; redirect_pc = 0; instr_ready = 0; rsp_en = 0;
    #2 reset = 1'b1;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_flush();
    test_redirect_collide();
    test_reset_mid();
`ifdef FETCH_PERF_EN
    test_perf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
